hms_timekeeper: RTL

Parametrised, fully synchronous HH:MM:SS timekeeping core for the 7-segment clock display path. It replaces ripple-clocked second/minute/hour counters with a single-clock prescaler and a carry chain. It adds an integrated set-mode FSM with synchronised, edge-detected buttons, and a 12/24-hour display mode. It drives BCD digit outputs directly into the segment controller.

---
 rtl/hms_timekeeper_if.sv | 32 +++
 rtl/hms_timekeeper.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/hms_timekeeper_if.sv
// Signal bundle between the HH:MM:SS timekeeper core and its user.
// The master drives the buttons and the display mode, and the slave (the core) drives the time/display outputs.
interface hms_timekeeper_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       mode_12h;
  logic [1:0] state;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] hrs_tens;
  logic [3:0] hrs_ones;
  logic [2:0] mins_tens;
  logic [3:0] mins_ones;
  logic [2:0] secs_tens;
  logic [3:0] secs_ones;
  logic       pm;
  logic       blink;
  logic       sec_tick;

  modport master (
    output btn_mode, btn_inc, mode_12h,
    input  state, hours, minutes, seconds, hrs_tens, hrs_ones,
           mins_tens, mins_ones, secs_tens, secs_ones, pm, blink, sec_tick
  );

  modport slave (
    input  btn_mode, btn_inc, mode_12h,
    output state, hours, minutes, seconds, hrs_tens, hrs_ones,
           mins_tens, mins_ones, secs_tens, secs_ones, pm, blink, sec_tick
  );
endinterface

// File: rtl/hms_timekeeper.sv
// Single-clock HH:MM:SS timekeeper with a prescaler, a carry chain, a button-driven set FSM
// and BCD display outputs in 12-hour or 24-hour format.
module hms_timekeeper #(
  parameter int PRESCALE    = 100_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  hms_timekeeper_if.slave        tk_io
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(PRESCALE / 2);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_SET_HR  = 2'd1;
  localparam logic [1:0] ST_SET_MIN = 2'd2;

  logic [SYNC_STAGES-1:0] modeSync_q, incSync_q;
  logic                   modeLast_q, incLast_q;
  logic                   modeP_q, incP_q;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    state_q, state_d;
  logic [4:0]    hours_q, hours_d;
  logic [5:0]    minutes_q, minutes_d;
  logic [5:0]    seconds_q, seconds_d;
  logic          secTick_q, secTick_d;
  logic          tick;

  // Each button is synchronised and then edge-detected into a registered one-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      modeSync_q <= '0;
      incSync_q  <= '0;
      modeLast_q <= 1'b0;
      incLast_q  <= 1'b0;
      modeP_q    <= 1'b0;
      incP_q     <= 1'b0;
    end else begin
      modeSync_q <= {modeSync_q[SYNC_STAGES-2:0], tk_io.btn_mode};
      incSync_q  <= {incSync_q[SYNC_STAGES-2:0], tk_io.btn_inc};
      modeLast_q <= modeSync_q[SYNC_STAGES-1];
      incLast_q  <= incSync_q[SYNC_STAGES-1];
      modeP_q    <= modeSync_q[SYNC_STAGES-1] & ~modeLast_q;
      incP_q     <= incSync_q[SYNC_STAGES-1] & ~incLast_q;
    end
  end

  assign tick = (presc_q == PRESC_MAX);

  always_comb begin
    state_d   = state_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    secTick_d = 1'b0;
    presc_d   = tick ? '0 : presc_q + PW'(1);
    case (state_q)
      ST_RUN: begin
        if (modeP_q) begin
          state_d = ST_SET_HR;
        end else if (tick) begin
          secTick_d = 1'b1;
          if (seconds_q == 6'd59) begin
            seconds_d = '0;
            if (minutes_q == 6'd59) begin
              minutes_d = '0;
              hours_d   = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
            end else begin
              minutes_d = minutes_q + 6'd1;
            end
          end else begin
            seconds_d = seconds_q + 6'd1;
          end
        end
      end
      ST_SET_HR: begin
        if (modeP_q) begin
          state_d = ST_SET_MIN;
        end else if (incP_q) begin
          hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
        end
      end
      ST_SET_MIN: begin
        // Leaving set mode restarts the second so the first tick is a full period away.
        if (modeP_q) begin
          state_d   = ST_RUN;
          seconds_d = '0;
          presc_d   = '0;
        end else if (incP_q) begin
          minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      state_q   <= ST_RUN;
      hours_q   <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
      secTick_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      state_q   <= state_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
      secTick_q <= secTick_d;
    end
  end

  function automatic logic [6:0] toBcd(input logic [5:0] v);
    logic [2:0] tens;
    logic [5:0] rem;
    tens = '0;
    rem  = v;
    for (int i = 0; i < 5; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 3'd1;
      end
    end
    return {tens, 4'(rem)};
  endfunction

  logic [4:0] dispHour;
  logic [6:0] hourBcd, minBcd, secBcd;

  // In 12-hour format midnight shows as 12 and afternoon hours fold back by 12.
  always_comb begin
    dispHour = hours_q;
    if (tk_io.mode_12h) begin
      if (hours_q == 5'd0) begin
        dispHour = 5'd12;
      end else if (hours_q > 5'd12) begin
        dispHour = hours_q - 5'd12;
      end
    end
  end

  assign hourBcd = toBcd({1'b0, dispHour});
  assign minBcd  = toBcd(minutes_q);
  assign secBcd  = toBcd(seconds_q);

  assign tk_io.state     = state_q;
  assign tk_io.hours     = hours_q;
  assign tk_io.minutes   = minutes_q;
  assign tk_io.seconds   = seconds_q;
  assign tk_io.hrs_tens  = 2'(hourBcd[6:4]);
  assign tk_io.hrs_ones  = hourBcd[3:0];
  assign tk_io.mins_tens = minBcd[6:4];
  assign tk_io.mins_ones = minBcd[3:0];
  assign tk_io.secs_tens = secBcd[6:4];
  assign tk_io.secs_ones = secBcd[3:0];
  assign tk_io.pm        = (hours_q >= 5'd12);
  assign tk_io.blink     = (presc_q < PRESC_HALF);
  assign tk_io.sec_tick  = secTick_q;

endmodule
